// File: rtl/ls_data_arbiter.sv
// ls_data_arbiter
// Shares one load/store data memory port between two requesters:
//   port 0 = core load/store unit, port 1 = auxiliary master.
// Round-robin arbitration with one outstanding access at a time, an
// optional access timeout, and a registered response path.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   req[1:0]                per-port request, held until the matching gnt bit
//   we/be/addr/wdata        per-port request fields, port p in slice p
//   gnt[1:0]                one-hot acceptance pulse (combinational)
//   ack[1:0]                one-hot completion pulse (registered)
//   err                     with ack: 1 = access aborted by timeout
//   rdata                   load data, valid with ack
//   mem_en/we/be/addr/wdata memory request, mem_en held until mem_ack
//   mem_rdata, mem_ack      memory load data and completion pulse
module ls_data_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    req,
  input  logic [1:0]                    we,
  input  logic [2*(DATA_WIDTH/8)-1:0]   be,
  input  logic [2*ADDR_WIDTH-1:0]       addr,
  input  logic [2*DATA_WIDTH-1:0]       wdata,
  output logic [1:0]                    gnt,
  output logic [1:0]                    ack,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [DATA_WIDTH/8-1:0]       mem_be,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          mem_ack
);

  localparam int BW = DATA_WIDTH / 8;
  // Counter is sized to hold TIMEOUT; it is a single bit when the timeout is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort fires on the edge where the counter would reach TIMEOUT, so
  // mem_en is high for exactly TIMEOUT cycles.
  localparam logic [CW-1:0] C_TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last_owner;
  logic                  r_owner;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [BW-1:0]         r_mem_be;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic [1:0]            w_gnt;
  logic                  w_grant;
  logic                  w_winner;
  logic                  w_done_ok;
  logic                  w_done_to;

  function automatic logic [1:0] f_onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, arbitration and completion decode
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 2'b00;
    w_grant     = 1'b0;
    w_winner    = 1'b0;
    w_done_ok   = 1'b0;
    w_done_to   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the port that did not own the last access wins.
        if (req == 2'b11) begin
          w_winner = ~r_last_owner;
        end else if (req == 2'b10) begin
          w_winner = 1'b1;
        end else begin
          w_winner = 1'b0;
        end
        if (req != 2'b00) begin
          w_grant     = 1'b1;
          w_gnt       = f_onehot(w_winner);
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        // mem_ack takes priority over a timeout in the same cycle.
        if (mem_ack) begin
          w_done_ok   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if ((TIMEOUT != 0) && (r_cnt == C_TO_LAST)) begin
          w_done_to   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latch, ownership, timeout counter and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_owner <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= {CW{1'b0}};
      r_ack        <= 2'b00;
      r_err        <= 1'b0;
      r_rdata      <= {DATA_WIDTH{1'b0}};
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= {BW{1'b0}};
      r_mem_addr   <= {ADDR_WIDTH{1'b0}};
      r_mem_wdata  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_ack <= 2'b00;
      r_err <= 1'b0;
      if (w_grant) begin
        r_owner      <= w_winner;
        r_last_owner <= w_winner;
        r_mem_en     <= 1'b1;
        r_cnt        <= {CW{1'b0}};
        r_mem_we     <= w_winner ? we[1] : we[0];
        r_mem_be     <= w_winner ? be[2*BW-1:BW] : be[BW-1:0];
        r_mem_addr   <= w_winner ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
        r_mem_wdata  <= w_winner ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
      end else if (w_done_ok) begin
        r_mem_en <= 1'b0;
        r_ack    <= f_onehot(r_owner);
        r_err    <= 1'b0;
        // Stores leave the last load data visible.
        if (!r_mem_we) begin
          r_rdata <= mem_rdata;
        end
      end else if (w_done_to) begin
        r_mem_en <= 1'b0;
        r_ack    <= f_onehot(r_owner);
        r_err    <= 1'b1;
      end else if (r_state == S_BUSY) begin
        // Saturating wait counter.
        if (r_cnt != {CW{1'b1}}) begin
          r_cnt <= r_cnt + C_CNT_ONE;
        end
      end
    end
  end

  assign gnt       = w_gnt;
  assign ack       = r_ack;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_ls_data_arbiter.sv
// Testbench for ls_data_arbiter (TIMEOUT = 4). A small responder answers
// mem_en after a chosen latency; expected results come from a round-robin /
// latency model kept here.
module tb_ls_data_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int TMO = 4;

  logic              clk;
  logic              reset;
  logic [1:0]        req;
  logic [1:0]        we;
  logic [2*BW-1:0]   be;
  logic [2*AW-1:0]   addr;
  logic [2*DW-1:0]   wdata;
  logic [1:0]        gnt;
  logic [1:0]        ack;
  logic              err;
  logic [DW-1:0]     rdata;
  logic              mem_en;
  logic              mem_we;
  logic [BW-1:0]     mem_be;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ack;

  logic              p_we    [2];
  logic [BW-1:0]     p_be    [2];
  logic [AW-1:0]     p_addr  [2];
  logic [DW-1:0]     p_wdata [2];

  int                lat;
  logic [DW-1:0]     next_rdata;
  logic              resp_ack;
  logic              stray_ack;

  int                ntests;
  int                nfail;
  int                m_last;
  logic [DW-1:0]     m_rdata;

  assign we      = {p_we[1], p_we[0]};
  assign be      = {p_be[1], p_be[0]};
  assign addr    = {p_addr[1], p_addr[0]};
  assign wdata   = {p_wdata[1], p_wdata[0]};
  assign mem_ack = resp_ack | stray_ack;

  ls_data_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: acks in the lat-th consecutive cycle of mem_en.
  initial begin : responder
    int bc;
    bc        = 0;
    resp_ack  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en === 1'b1) begin
        bc++;
        if (bc == lat) begin
          resp_ack  = 1'b1;
          mem_rdata = next_rdata;
        end else begin
          resp_ack = 1'b0;
        end
      end else begin
        bc       = 0;
        resp_ack = 1'b0;
      end
    end
  end

  function automatic logic [1:0] onehot(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic rand_fields();
    for (int p = 0; p < 2; p++) begin
      p_we[p]    = 1'($urandom_range(0, 1));
      p_be[p]    = BW'($urandom);
      p_addr[p]  = AW'($urandom);
      p_wdata[p] = DW'($urandom);
    end
    next_rdata = DW'($urandom);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req       = 2'b00;
    stray_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    m_last  = 1;
    m_rdata = '0;
  endtask

  // One complete access; caller is at posedge+1 with the DUT idle.
  task automatic run_access(input logic [1:0] rq, input int l, input string tag);
    int   w;
    int   exp_en;
    int   en_cyc;
    bit   got;
    bit   exp_err;
    lat     = l;
    w       = (rq == 2'b11) ? (1 - m_last) : ((rq == 2'b10) ? 1 : 0);
    exp_err = (TMO > 0) && (l > TMO);
    exp_en  = exp_err ? TMO : l;
    req     = rq;
    @(negedge clk);
    ntests++;
    if (gnt !== onehot(w)) begin
      nfail++;
      $display("FAIL %s gnt: got %b expected %b", tag, gnt, onehot(w));
    end
    @(posedge clk);
    #1;
    req    = 2'b00;
    m_last = w;
    en_cyc = 0;
    got    = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin
        got = 1'b1;
      end else begin
        if (mem_en === 1'b1) begin
          en_cyc++;
          ntests++;
          if ({mem_we, mem_be, mem_addr, mem_wdata} !== {p_we[w], p_be[w], p_addr[w], p_wdata[w]}) begin
            nfail++;
            $display("FAIL %s mem_fields: got we=%b be=%h addr=%h wd=%h expected we=%b be=%h addr=%h wd=%h",
                     tag, mem_we, mem_be, mem_addr, mem_wdata, p_we[w], p_be[w], p_addr[w], p_wdata[w]);
          end
        end
        @(posedge clk);
        #1;
      end
    end
    ntests++;
    if (!got) begin
      nfail++;
      $display("FAIL %s ack_wait: no ack within bound, expected %b", tag, onehot(w));
    end else begin
      if (!exp_err && !p_we[w]) m_rdata = next_rdata;
      if ({ack, err, mem_en} !== {onehot(w), exp_err, 1'b0}) begin
        nfail++;
        $display("FAIL %s ack: got ack=%b err=%b mem_en=%b expected ack=%b err=%b mem_en=0",
                 tag, ack, err, mem_en, onehot(w), exp_err);
      end
      ntests++;
      if (rdata !== m_rdata) begin
        nfail++;
        $display("FAIL %s rdata: got %h expected %h", tag, rdata, m_rdata);
      end
      ntests++;
      if (en_cyc != exp_en) begin
        nfail++;
        $display("FAIL %s mem_en_cycles: got %0d expected %0d", tag, en_cyc, exp_en);
      end
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    ntests++;
    if ({ack, mem_en} !== 3'b000) begin
      nfail++;
      $display("FAIL %s ack_pulse: got ack=%b mem_en=%b expected 00/0", tag, ack, mem_en);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    ntests++;
    if ({gnt, ack, err, mem_en, rdata, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      nfail++;
      $display("FAIL reset_state: got gnt=%b ack=%b err=%b en=%b rdata=%h addr=%h expected all zero",
               gnt, ack, err, mem_en, rdata, mem_addr);
    end
    apply_reset();
    @(negedge clk);
    ntests++;
    if ({gnt, mem_en} !== 3'b000) begin
      nfail++;
      $display("FAIL idle_no_req: got gnt=%b mem_en=%b expected 00/0", gnt, mem_en);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_load();
    rand_fields();
    p_addr[0]  = 32'h0000_0100;
    p_we[0]    = 1'b0;
    next_rdata = 32'hDEAD_BEEF;
    run_access(2'b01, 3, "single_load");
    ntests++;
    if (rdata !== 32'hDEAD_BEEF) begin
      nfail++;
      $display("FAIL single_load_value: got %h expected deadbeef", rdata);
    end
  endtask

  task automatic test_store_port1();
    rand_fields();
    p_we[1]    = 1'b1;
    p_be[1]    = 4'b0011;
    p_wdata[1] = 32'h1234_5678;
    run_access(2'b10, 2, "store_p1");
  endtask

  task automatic test_fairness();
    int exp_w;
    int prev;
    apply_reset();
    rand_fields();
    p_we[0] = 1'b0;
    p_we[1] = 1'b0;
    lat     = 1;
    prev    = 0;
    req     = 2'b11;
    for (int n = 0; n < 4; n++) begin
      exp_w = 1 - m_last;
      @(negedge clk);
      ntests++;
      if (gnt !== onehot(exp_w)) begin
        nfail++;
        $display("FAIL fair_gnt[%0d]: got %b expected %b", n, gnt, onehot(exp_w));
      end
      if (n > 0) begin
        ntests++;
        if ({ack, rdata} !== {onehot(prev), m_rdata}) begin
          nfail++;
          $display("FAIL fair_ack_overlap[%0d]: got ack=%b rdata=%h expected ack=%b rdata=%h",
                   n, ack, rdata, onehot(prev), m_rdata);
        end
      end
      @(posedge clk);
      #1;
      m_last = exp_w;
      prev   = exp_w;
      if (n == 3) req = 2'b00;
      @(negedge clk);
      ntests++;
      if ({mem_en, mem_addr} !== {1'b1, p_addr[exp_w]}) begin
        nfail++;
        $display("FAIL fair_mem[%0d]: got en=%b addr=%h expected en=1 addr=%h", n, mem_en, mem_addr, p_addr[exp_w]);
      end
      m_rdata = next_rdata;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    ntests++;
    if ({ack, gnt} !== {onehot(prev), 2'b00}) begin
      nfail++;
      $display("FAIL fair_last_ack: got ack=%b gnt=%b expected ack=%b gnt=00", ack, gnt, onehot(prev));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_busy_other();
    int  en_cyc;
    bit  got;
    rand_fields();
    p_we[0] = 1'b0;
    p_we[1] = 1'b1;
    lat     = 3;
    req     = 2'b01;
    @(negedge clk);
    ntests++;
    if (gnt !== 2'b01) begin
      nfail++;
      $display("FAIL busy_first_gnt: got %b expected 01", gnt);
    end
    @(posedge clk);
    #1;
    req    = 2'b10;
    m_last = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ntests++;
      if ({gnt, mem_en, mem_addr} !== {2'b00, 1'b1, p_addr[0]}) begin
        nfail++;
        $display("FAIL busy_hold[%0d]: got gnt=%b en=%b addr=%h expected 00/1/%h", c, gnt, mem_en, mem_addr, p_addr[0]);
      end
      @(posedge clk);
      #1;
    end
    m_rdata = next_rdata;
    @(negedge clk);
    ntests++;
    if ({ack, gnt, rdata} !== {2'b01, 2'b10, m_rdata}) begin
      nfail++;
      $display("FAIL busy_handover: got ack=%b gnt=%b rdata=%h expected 01/10/%h", ack, gnt, rdata, m_rdata);
    end
    @(posedge clk);
    #1;
    req    = 2'b00;
    m_last = 1;
    en_cyc = 0;
    got    = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin
        got = 1'b1;
      end else begin
        if (mem_en === 1'b1) en_cyc++;
        @(posedge clk);
        #1;
      end
    end
    ntests++;
    if (!got || {ack, err, rdata} !== {2'b10, 1'b0, m_rdata} || en_cyc != 3) begin
      nfail++;
      $display("FAIL busy_second: got ack=%b err=%b rdata=%h en_cycles=%0d expected 10/0/%h/3",
               ack, err, rdata, en_cyc, m_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    rand_fields();
    run_access(2'b01, 100, "timeout_never");
    rand_fields();
    run_access(2'b10, 5, "timeout_late");
    rand_fields();
    run_access(2'b01, 4, "ack_at_limit");
    rand_fields();
    run_access(2'b10, 2, "after_timeout");
  endtask

  task automatic test_reset_mid();
    rand_fields();
    lat = 100;
    req = 2'b10;
    @(negedge clk);
    ntests++;
    if (gnt !== onehot(2 - 1 - m_last + (m_last == 1 ? 1 : 0) - (m_last == 1 ? 1 : 0) + 0) && gnt !== 2'b10) begin
      nfail++;
      $display("FAIL rst_mid_gnt: got %b expected 10", gnt);
    end
    @(posedge clk);
    #1;
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    ntests++;
    if ({mem_en, ack, err} !== 4'b0000) begin
      nfail++;
      $display("FAIL rst_mid_abort: got en=%b ack=%b err=%b expected 0/00/0", mem_en, ack, err);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    m_last    = 1;
    m_rdata   = '0;
    stray_ack = 1'b1;
    @(posedge clk);
    #1;
    stray_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ntests++;
      if ({ack, mem_en, rdata} !== {2'b00, 1'b0, m_rdata}) begin
        nfail++;
        $display("FAIL stray_ack[%0d]: got ack=%b en=%b rdata=%h expected 00/0/%h", c, ack, mem_en, rdata, m_rdata);
      end
      @(posedge clk);
      #1;
    end
    rand_fields();
    run_access(2'b11, 2, "post_reset_tie");
  endtask

  task automatic test_random();
    logic [1:0] rq;
    for (int i = 0; i < 40; i++) begin
      rand_fields();
      rq = 2'($urandom_range(1, 3));
      run_access(rq, $urandom_range(1, 6), "random");
    end
  endtask

  initial begin
    ntests     = 0;
    nfail      = 0;
    m_last     = 1;
    m_rdata    = '0;
    reset      = 1'b1;
    req        = 2'b00;
    lat        = 1;
    stray_ack  = 1'b0;
    next_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      p_we[p]    = 1'b0;
      p_be[p]    = '0;
      p_addr[p]  = '0;
      p_wdata[p] = '0;
    end
    test_reset();
    test_single_load();
    test_store_port1();
    test_fairness();
    test_busy_other();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/ls_data_arbiter.md
Name: ls_data_arbiter

Overview:
- Shares the single load/store data memory port between two requesters:
  - port 0: core load/store unit.
  - port 1: auxiliary master (I/O or vector unit).
- Round-robin arbitration, one outstanding access at a time, optional access timeout.
- Registered response path: read data and acknowledge return to the owning requester.
- Sits between the load/store data interface users and the data memory.

Parameters:
- ADDR_WIDTH, 32, byte address width of requests and of the memory port.
- DATA_WIDTH, 32, data word width; must be a multiple of 8.
- TIMEOUT, 0, cycles to wait for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req  in  2  request per port; held until the matching gnt bit
- we  in  2  per-port write enable (1 = store)
- be  in  2*DATA_WIDTH/8  per-port byte enables, port p at slice [p*DATA_WIDTH/8 +: DATA_WIDTH/8]
- addr  in  2*ADDR_WIDTH  per-port address slices
- wdata  in  2*DATA_WIDTH  per-port store data slices
- gnt  out  2  one-hot acceptance pulse, combinational
- ack  out  2  one-hot completion pulse, registered
- err  out  1  valid with ack; 1 = access aborted by timeout
- rdata  out  DATA_WIDTH  load data, valid with ack
- mem_en  out  1  memory access strobe, level, held until mem_ack
- mem_we  out  1  memory write enable
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory store data
- mem_rdata  in  DATA_WIDTH  memory load data, valid with mem_ack
- mem_ack  in  1  memory completion pulse

Behaviour:
- Reset:
  - Asynchronous; state IDLE, last_owner = 1 (port 0 wins the first tie).
  - mem_en, ack, err, gnt all 0; rdata, mem_* registers all 0; timeout counter 0.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any req bit is set, gnt fires in the same cycle (combinational from state and req).
  - Single requester: that port wins.
  - Both requesting: the port != last_owner wins.
  - On grant, at the clock edge: latch we/be/addr/wdata of the winner into mem_* registers, set owner and last_owner, assert mem_en, go to BUSY.
  - No grant in IDLE when req == 0.
- BUSY:
  - gnt = 0 regardless of req.
  - mem_* registers stay stable; mem_en stays 1 until mem_ack is sampled high.
  - On mem_ack: mem_en drops next cycle; rdata <= mem_rdata (loads only; stores leave rdata unchanged); ack[owner] <= 1 and err <= 0 for exactly one cycle; return to IDLE.
- Latency:
  - gnt at cycle 0, mem_en in cycles 1..k, mem_ack at cycle k, ack at cycle k+1.
  - A new gnt is possible in cycle k+1, the same cycle ack is high.
  - Back-to-back throughput: one access per (memory latency + 1) cycles.
- Timeout (TIMEOUT > 0):
  - Counter clears on entry to BUSY and increments each BUSY cycle without mem_ack.
  - When it reaches TIMEOUT: drop mem_en, pulse ack[owner] with err = 1, leave rdata unchanged, return to IDLE.
  - mem_ack and timeout in the same cycle: mem_ack wins, err = 0.
- mem_ack sampled while IDLE is ignored and produces no ack.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1.
- req deasserted before gnt is legal and drops the request. A port must not change its request fields while its req is high and ungranted.
- Reset mid-access: immediate return to IDLE with mem_en = 0. No ack is issued for the aborted access; the memory side is reset by the same signal.
- Arithmetic: timeout counter is $clog2(TIMEOUT+1) bits and saturates; no wrap-around.

Test Plan:
- Single load, port 0: req = 01, addr 0x100, memory acks 3 cycles after mem_en with 0xDEADBEEF -> gnt = 01 at cycle 0; mem_en cycles 1-3; ack = 01, rdata = 0xDEADBEEF, err = 0 at cycle 4.
- Simultaneous requests held high for 4 accesses, memory latency 1 -> grant order 0,1,0,1 (first after reset goes to port 0); mem_addr matches each winner's addr.
- Store from port 1: we = 1, be = 0011, wdata 0x12345678 -> mem_we = 1, mem_be = 0011, mem_wdata = 0x12345678; ack = 10; rdata unchanged from the previous load.
- TIMEOUT = 4, memory never acks -> mem_en high for 4 cycles then 0; ack[owner] = 1 with err = 1; next request is granted normally.
- Async reset asserted while BUSY -> mem_en = 0 and state IDLE before the next edge; no ack pulse; stray mem_ack afterwards is ignored.
- Request while BUSY on the other port -> gnt stays 0 until the cycle after the current mem_ack, then that port is granted the same cycle ack fires for the first port.
